// File: rtl/fmuls_unit.sv
// fmuls_unit: AVR FMULS datapath. Signed 1.7 x signed 1.7 multiply through an
// explicit sign-extended partial-product array, product shifted left by one to
// give a signed 1.15 result, with carry and zero flags. One register stage.
module fmuls_unit (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_en,
    input  logic [7:0] i_rd,
    input  logic [7:0] i_rr,
    output logic [7:0] o_r1,
    output logic [7:0] o_r0,
    output logic       o_c,
    output logic       o_z,
    output logic       o_valid
);

    // Signed array multiply: rows 0..6 add the sign-extended multiplicand
    // shifted by the row index; row 7 carries weight -2^7 and is subtracted.
    function automatic logic signed [15:0] array_mul(
        input logic signed [7:0] a,
        input logic signed [7:0] b
    );
        logic signed [15:0] acc;
        logic signed [15:0] a_ext;
        acc   = '0;
        a_ext = {{8{a[7]}}, a};
        for (int j = 0; j < 7; j++) begin
            if (b[j]) begin
                acc = acc + (a_ext <<< j);
            end
        end
        if (b[7]) begin
            acc = acc - (a_ext <<< 7);
        end
        return acc;
    endfunction

    // Fractional alignment: 2.14 product becomes 1.15 by dropping the top
    // bit. No saturation, so -1.0 * -1.0 wraps to 0x8000 as on AVR.
    function automatic logic [15:0] frac_shift(input logic signed [15:0] p);
        return {p[14:0], 1'b0};
    endfunction

    logic signed [7:0]  rd_s;
    logic signed [7:0]  rr_s;
    logic signed [15:0] prod;
    logic [15:0]        res_d;
    logic               c_d;
    logic               z_d;

    logic [15:0]        res_q;
    logic               c_q;
    logic               z_q;
    logic               valid_q;

    assign rd_s = $signed(i_rd);
    assign rr_s = $signed(i_rr);

    // Combinational product, shifted result and flags for the current operands.
    always_comb begin
        prod  = array_mul(rd_s, rr_s);
        res_d = frac_shift(prod);
        c_d   = prod[15];
        z_d   = (res_d == 16'h0000);
    end

    // Result and flags load only on enable, so idle operands never reach them.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            res_q <= 16'h0000;
            c_q   <= 1'b0;
            z_q   <= 1'b0;
        end else if (i_en) begin
            res_q <= res_d;
            c_q   <= c_d;
            z_q   <= z_d;
        end
    end

    // Valid pulses for exactly one cycle after each enabled cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= i_en;
        end
    end

    assign o_r1    = res_q[15:8];
    assign o_r0    = res_q[7:0];
    assign o_c     = c_q;
    assign o_z     = z_q;
    assign o_valid = valid_q;

endmodule

// File: tb/tb_fmuls_unit.sv
// Directed and exhaustive bench for fmuls_unit.
module tb_fmuls_unit;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] rd;
    logic [7:0] rr;
    logic [7:0] r1;
    logic [7:0] r0;
    logic       c;
    logic       z;
    logic       valid;

    int total;
    int bad;

    fmuls_unit dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_en    (en),
        .i_rd    (rd),
        .i_rr    (rr),
        .o_r1    (r1),
        .o_r0    (r0),
        .o_c     (c),
        .o_z     (z),
        .o_valid (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset asserted between edges clears outputs at once; stays clear after release with en low.
    task automatic test_reset();
        logic [11:0] got;
        // Load a nonzero result first so the clear is observable.
        en = 1'b1; rd = 8'h40; rr = 8'hC0;
        tick();
        en = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        got = {r1, r0, c, z, valid};
        total++;
        if (got !== 19'h0) begin
            bad++;
            $display("FAIL reset_async: got r1=%02h r0=%02h c=%b z=%b v=%b required all 0", r1, r0, c, z, valid);
        end
        #2;
        rst_n = 1'b1;
        tick();
        tick();
        total++;
        if ({r1, r0, c, z, valid} !== 19'h0) begin
            bad++;
            $display("FAIL reset_release_idle: got r1=%02h r0=%02h c=%b z=%b v=%b required all 0", r1, r0, c, z, valid);
        end
        // Reset held across an edge with en high: reset wins.
        rst_n = 1'b0; en = 1'b1; rd = 8'h40; rr = 8'h40;
        tick();
        total++;
        if ({r1, r0, c, z, valid} !== 19'h0) begin
            bad++;
            $display("FAIL reset_wins_en: got r1=%02h r0=%02h c=%b z=%b v=%b required all 0", r1, r0, c, z, valid);
        end
        en = 1'b0;
        rst_n = 1'b1;
        tick();
    endtask

    // -1.0 x -1.0 wraps to 0x8000.
    task automatic test_overflow_corner();
        en = 1'b1; rd = 8'h80; rr = 8'h80;
        tick();
        en = 1'b0;
        total++;
        if ({r1, r0, c, z, valid} !== {8'h80, 8'h00, 1'b0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL corner_80x80: got r1=%02h r0=%02h c=%b z=%b v=%b required 80 00 0 0 1", r1, r0, c, z, valid);
        end
        tick();
        total++;
        if (valid !== 1'b0) begin
            bad++;
            $display("FAIL valid_single_pulse: got v=%b required 0", valid);
        end
    endtask

    // Zero operand gives zero result with Z set.
    task automatic test_zero();
        en = 1'b1; rd = 8'h80; rr = 8'h00;
        tick();
        en = 1'b0;
        total++;
        if ({r1, r0, c, z, valid} !== {8'h00, 8'h00, 1'b0, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL zero_80x00: got r1=%02h r0=%02h c=%b z=%b v=%b required 00 00 0 1 1", r1, r0, c, z, valid);
        end
    endtask

    // 0.5 x 0.5 followed immediately by 0x01 x 0x01.
    task automatic test_back_to_back();
        en = 1'b1; rd = 8'h40; rr = 8'h40;
        tick();
        rd = 8'h01; rr = 8'h01;
        total++;
        if ({r1, r0, c, z, valid} !== {8'h20, 8'h00, 1'b0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL b2b_first_40x40: got r1=%02h r0=%02h c=%b z=%b v=%b required 20 00 0 0 1", r1, r0, c, z, valid);
        end
        tick();
        en = 1'b0;
        total++;
        if ({r1, r0, c, z, valid} !== {8'h00, 8'h02, 1'b0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL b2b_second_01x01: got r1=%02h r0=%02h c=%b z=%b v=%b required 00 02 0 0 1", r1, r0, c, z, valid);
        end
    endtask

    // 0.5 x -0.5 gives negative result with carry.
    task automatic test_negative();
        en = 1'b1; rd = 8'h40; rr = 8'hC0;
        tick();
        en = 1'b0;
        total++;
        if ({r1, r0, c, z, valid} !== {8'hE0, 8'h00, 1'b1, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL neg_40xC0: got r1=%02h r0=%02h c=%b z=%b v=%b required E0 00 1 0 1", r1, r0, c, z, valid);
        end
    endtask

    // Dropping en for a cycle clears valid and holds the result.
    task automatic test_hold();
        en = 1'b1; rd = 8'h7F; rr = 8'h81;
        tick();
        // 127 * -127 = -16129 = 0xC0FF; <<1 = 0x81FE; c = 1
        total++;
        if ({r1, r0, c, z, valid} !== {8'h81, 8'hFE, 1'b1, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL hold_load_7Fx81: got r1=%02h r0=%02h c=%b z=%b v=%b required 81 FE 1 0 1", r1, r0, c, z, valid);
        end
        en = 1'b0; rd = 8'h00; rr = 8'h00;
        tick();
        total++;
        if ({r1, r0, c, z, valid} !== {8'h81, 8'hFE, 1'b1, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL hold_idle: got r1=%02h r0=%02h c=%b z=%b v=%b required 81 FE 1 0 0", r1, r0, c, z, valid);
        end
        en = 1'b1; rd = 8'hFF; rr = 8'hFF;
        tick();
        en = 1'b0;
        // -1 * -1 = 1; <<1 = 0x0002
        total++;
        if ({r1, r0, c, z, valid} !== {8'h00, 8'h02, 1'b0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL hold_resume_FFxFF: got r1=%02h r0=%02h c=%b z=%b v=%b required 00 02 0 0 1", r1, r0, c, z, valid);
        end
    endtask

    // Every operand pair, one per cycle with en held high.
    task automatic test_sweep();
        logic signed [15:0] p;
        logic [15:0]        r;
        logic [18:0]        exp;
        en = 1'b1;
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 256; b++) begin
                rd = 8'(a);
                rr = 8'(b);
                tick();
                p   = $signed(rd) * $signed(rr);
                r   = {p[14:0], 1'b0};
                exp = {r, p[15], (r == 16'h0000), 1'b1};
                total++;
                if ({r1, r0, c, z, valid} !== exp) begin
                    bad++;
                    $display("FAIL sweep rd=%02h rr=%02h: got %02h%02h c=%b z=%b v=%b required %04h c=%b z=%b v=1",
                             rd, rr, r1, r0, c, z, valid, r, exp[2], exp[1]);
                end
            end
        end
        en = 1'b0;
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b1;
        en    = 1'b0;
        rd    = 8'h00;
        rr    = 8'h00;
        #1;
        test_reset();
        test_overflow_corner();
        test_zero();
        test_back_to_back();
        test_negative();
        test_hold();
        test_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
